// File: rtl/spi_daq_pkg.sv
// Shared types and constants for the SPI DAQ datapath: sampler FSM states,
// the sample width used by the FIFO, and the sampler debug view.
package spi_daq_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    PUSH
  } sampler_state_e;

  typedef struct packed {
    sampler_state_e state;
    logic           sclk_rise;
    logic           sclk_fall;
    logic [7:0]     edge_cnt;
  } sampler_dbg_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_adc_sampler_if.sv
// Sampler-to-ADC serial pins and sampler-to-FIFO push port.
// write_en is a one-cycle push strobe with no back-pressure; fifo_full only
// decides whether a finished sample is pushed or dropped, never stalls.
interface spi_adc_sampler_if #(
  parameter int WIDTH = 16
);
  logic             sclk;
  logic             cs_n;
  logic             miso;
  logic             write_en;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;

  modport master (
    output sclk, cs_n, write_en, data_out,
    input  miso, fifo_full
  );

  modport slave (
    input  sclk, cs_n, write_en, data_out,
    output miso, fifo_full
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: one burst of WIDTH sclk periods per start pulse,
// each half-period CLK_DIV clk cycles, ending with sclk low for a final half.
module spi_sclk_gen #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4,
  localparam int EDGE_W = $clog2(2 * WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              sclk,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              done,
  output logic [EDGE_W-1:0] edge_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             running;
  logic [DIV_W-1:0] div_cnt;
  logic             half_end;
  logic             last_half;

  // edge_cnt indexes half-periods; even halves are sclk high, odd halves low
  assign half_end   = running && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_half  = (edge_cnt == EDGE_W'(2 * WIDTH - 1));
  assign rise_pulse = start || (half_end && !sclk && !last_half);
  assign fall_pulse = half_end && sclk;
  assign done       = half_end && last_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else if (start) begin
      running  <= 1'b1;
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b1;
    end else if (running) begin
      if (half_end) begin
        div_cnt <= '0;
        if (last_half) begin
          running <= 1'b0;
          sclk    <= 1'b0;
        end else begin
          edge_cnt <= edge_cnt + EDGE_W'(1);
          sclk     <= ~sclk;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_adc_sampler.sv
// Periodic SPI-master ADC sampler: every SAMPLE_PERIOD clocks it reads one
// WIDTH-bit sample MSB-first and pushes it to a FIFO, dropping it when full.
module spi_adc_sampler
  import spi_daq_pkg::*;
#(
  parameter int WIDTH         = SAMPLE_W,
  parameter int CLK_DIV       = 4,
  parameter int CS_SETUP      = 2,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  spi_adc_sampler_if.master        bus,
  output logic                     busy,
  output logic [15:0]              overrun_cnt,
  output sampler_dbg_t             dbg
);

  localparam int PER_W  = $clog2(SAMPLE_PERIOD);
  localparam int SET_W  = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH);

  if (SAMPLE_PERIOD <= CS_SETUP + 2 * WIDTH * CLK_DIV + 2 || CLK_DIV < 1 ||
      CS_SETUP < 1 || WIDTH < 2) begin : g_bad_params
    $error("spi_adc_sampler: SAMPLE_PERIOD must exceed one full conversion");
  end

  sampler_state_e    state;
  logic [PER_W-1:0]  period_cnt;
  logic [SET_W-1:0]  setup_cnt;
  logic [WIDTH-1:0]  shift_reg;
  logic [15:0]       overrun_q;
  logic              tick;
  logic              sclk_start;
  logic              rise_pulse;
  logic              fall_pulse;
  logic              shift_done;
  logic [EDGE_W-1:0] edge_cnt;

  assign tick       = enable && (period_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign sclk_start = (state == SETUP) && (setup_cnt == SET_W'(CS_SETUP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (!enable || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PER_W'(1);
    end
  end

  spi_sclk_gen #(
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (sclk_start),
    .sclk       (bus.sclk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .done       (shift_done),
    .edge_cnt   (edge_cnt)
  );

  // The push decision is taken on the edge entering PUSH so that write_en and
  // data_out are registered and valid for exactly the PUSH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      setup_cnt    <= '0;
      shift_reg    <= '0;
      overrun_q    <= '0;
      busy         <= 1'b0;
      bus.cs_n     <= 1'b1;
      bus.write_en <= 1'b0;
      bus.data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state     <= SETUP;
            setup_cnt <= '0;
            busy      <= 1'b1;
            bus.cs_n  <= 1'b0;
          end
        end
        SETUP: begin
          if (sclk_start) begin
            state <= SHIFT;
          end else begin
            setup_cnt <= setup_cnt + SET_W'(1);
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state    <= HOLD;
            bus.cs_n <= 1'b1;
          end
        end
        HOLD: begin
          state <= PUSH;
          if (!bus.fifo_full) begin
            bus.write_en <= 1'b1;
            bus.data_out <= shift_reg;
          end else begin
            overrun_q <= sat_inc16(overrun_q);
          end
        end
        PUSH: begin
          state        <= IDLE;
          busy         <= 1'b0;
          bus.write_en <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          bus.cs_n     <= 1'b1;
          bus.write_en <= 1'b0;
        end
      endcase

      if (rise_pulse) begin
        shift_reg <= {shift_reg[WIDTH-2:0], bus.miso};
      end
    end
  end

  assign overrun_cnt   = overrun_q;
  assign dbg.state     = state;
  assign dbg.sclk_rise = rise_pulse;
  assign dbg.sclk_fall = fall_pulse;
  assign dbg.edge_cnt  = 8'(edge_cnt);

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Bench for spi_adc_sampler: an ADC model on the serial pins, an event
// monitor, table-driven and random conversions, and reset/enable corners.
module tb_spi_adc_sampler;
  import spi_daq_pkg::*;

  localparam int W      = 16;
  localparam int DIV    = 2;
  localparam int CS_SET = 2;
  localparam int PER    = 100;
  localparam int CS_LOW = CS_SET + 2 * W * DIV;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         busy;
  logic [15:0]  overrun_cnt;
  sampler_dbg_t dbg;

  spi_adc_sampler_if #(.WIDTH(W)) bus ();

  spi_adc_sampler #(
    .WIDTH         (W),
    .CLK_DIV       (DIV),
    .CS_SETUP      (CS_SET),
    .SAMPLE_PERIOD (PER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .dbg         (dbg)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // monitor + ADC model: records serial/FIFO events, drives miso MSB-first
  logic [15:0] adc_word = '0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_we = 1'b0;
  int fall_cyc = -1, rise_cyc = -1, we_cyc = -1;
  int falls_seen = 0, rises_seen = 0, we_seen = 0;
  int sclk_rises = 0, sclk_falls = 0, total_rises = 0;
  int we_double = 0, sclk_bad = 0, bit_idx;

  always @(negedge clk) begin
    if (prev_cs && !bus.cs_n) begin
      fall_cyc = cyc; falls_seen++; sclk_rises = 0; sclk_falls = 0;
    end
    if (!prev_cs && bus.cs_n) begin rise_cyc = cyc; rises_seen++; end
    if (!prev_sclk && bus.sclk) begin sclk_rises++; total_rises++; end
    if (prev_sclk && !bus.sclk) sclk_falls++;
    if (bus.write_en) begin we_cyc = cyc; we_seen++; end
    if (bus.write_en && prev_we) we_double++;
    if (bus.cs_n && bus.sclk) sclk_bad++;
    prev_cs = bus.cs_n; prev_sclk = bus.sclk; prev_we = bus.write_en;
    bit_idx = W - 1 - sclk_falls;
    if (bit_idx < 0) bit_idx = 0;
    bus.miso = bus.cs_n ? 1'b0 : adc_word[bit_idx];
  end

  // scoreboard counters and helpers
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fall(input int n0);
    int b = 0;
    while (falls_seen == n0 && b < 2 * PER) begin step(); b++; end
  endtask

  task automatic wait_rise(input int n0);
    int b = 0;
    while (rises_seen == n0 && b < 2 * PER) begin step(); b++; end
  endtask

  // one full conversion, checked against expected timing and FIFO result
  task automatic do_conv(input logic [15:0] word, input logic full, input int exp_fall,
                         input logic exp_we, input logic [15:0] exp_data,
                         input logic [15:0] exp_ovr, input string tag);
    adc_word      = word;
    bus.fifo_full = full;
    wait_fall(falls_seen);
    check({tag, "_cs_fall_cyc"}, fall_cyc, exp_fall);
    wait_rise(rises_seen);
    check({tag, "_cs_low_len"}, rise_cyc - fall_cyc, CS_LOW);
    check({tag, "_sclk_rises"}, sclk_rises, W);
    step();
    check({tag, "_write_en"}, bus.write_en, exp_we);
    check({tag, "_data_out"}, bus.data_out, exp_data);
    if (exp_we) check({tag, "_we_cyc"}, we_cyc, exp_fall + CS_LOW + 1);
    step();
    check({tag, "_we_single"}, bus.write_en, 1'b0);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_overrun"}, overrun_cnt, exp_ovr);
  endtask

  typedef struct {
    logic [15:0] word;
    logic        full;
    logic        exp_we;
    logic [15:0] exp_data;
    logic [15:0] exp_ovr;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] model_data, model_ovr, rword;
  logic        rfull;
  int          next_fall, n0, b, we0, f0, r0;
  bit          busy_seen;

  initial begin
    vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 16'hA5C3, 16'd0};
    vecs[1] = '{16'h0001, 1'b0, 1'b1, 16'h0001, 16'd0};
    vecs[2] = '{16'h8000, 1'b0, 1'b1, 16'h8000, 16'd0};
    vecs[3] = '{16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 16'd0};
    vecs[4] = '{16'h1234, 1'b1, 1'b0, 16'hFFFF, 16'd1};
    vecs[5] = '{16'h5A5A, 1'b0, 1'b1, 16'h5A5A, 16'd1};
    vecs[6] = '{16'h0F0F, 1'b1, 1'b0, 16'h5A5A, 16'd2};

    bus.fifo_full = 1'b0;
    bus.miso      = 1'b0;

    // reset values, during and after reset with enable low
    repeat (3) step();
    check("rst_cs_n", bus.cs_n, 1'b1);
    check("rst_sclk", bus.sclk, 1'b0);
    check("rst_write_en", bus.write_en, 1'b0);
    check("rst_data_out", bus.data_out, 16'h0);
    rst_n = 1'b1;
    repeat (150) step();
    check("idle_busy", busy, 1'b0);
    check("idle_overrun", overrun_cnt, 16'h0);
    check("idle_state", dbg.state, IDLE);
    check("idle_cs_falls", falls_seen, 0);
    check("idle_sclk_rises", total_rises, 0);

    // table-driven back-to-back conversions
    enable    = 1'b1;
    next_fall = cyc + PER;
    for (int i = 0; i < 7; i++) begin
      do_conv(vecs[i].word, vecs[i].full, next_fall, vecs[i].exp_we,
              vecs[i].exp_data, vecs[i].exp_ovr, $sformatf("vec%0d", i));
      next_fall += PER;
    end
    model_data = 16'h5A5A;
    model_ovr  = 16'd2;

    // random samples against the reference model
    for (int i = 0; i < 8; i++) begin
      rword = 16'($urandom_range(0, 16'hFFFF));
      rfull = ($urandom_range(0, 3) == 0);
      if (!rfull) model_data = rword;
      else model_ovr = (model_ovr == 16'hFFFF) ? model_ovr : model_ovr + 16'd1;
      do_conv(rword, rfull, next_fall, !rfull, model_data, model_ovr,
              $sformatf("rand%0d", i));
      next_fall += PER;
    end

    // overrun counter saturation
    force dut.overrun_q = 16'hFFFF;
    step();
    release dut.overrun_q;
    step();
    check("sat_preload", overrun_cnt, 16'hFFFF);
    do_conv(16'h7777, 1'b1, next_fall, 1'b0, model_data, 16'hFFFF, "sat_full");
    next_fall += PER;
    do_conv(16'h2468, 1'b0, next_fall, 1'b1, 16'h2468, 16'hFFFF, "sat_ok");
    next_fall += PER;

    // enable dropped at the 5th sclk edge: conversion still completes
    adc_word      = 16'hC0DE;
    bus.fifo_full = 1'b0;
    wait_fall(falls_seen);
    check("endrop_cs_fall_cyc", fall_cyc, next_fall);
    b = 0;
    while (sclk_rises + sclk_falls < 5 && b < 40) begin step(); b++; end
    enable = 1'b0;
    wait_rise(rises_seen);
    step();
    check("endrop_write_en", bus.write_en, 1'b1);
    check("endrop_data_out", bus.data_out, 16'hC0DE);
    we0 = we_seen;
    f0  = falls_seen;
    repeat (2 * PER) step();
    check("endrop_no_cs", falls_seen, f0);
    check("endrop_no_we", we_seen, we0);
    check("endrop_busy", busy, 1'b0);
    enable    = 1'b1;
    next_fall = cyc + PER;

    // asynchronous reset mid-SHIFT
    adc_word = 16'hBEEF;
    wait_fall(falls_seen);
    check("reen_cs_fall_cyc", fall_cyc, next_fall);
    b = 0;
    while (!(bus.sclk && sclk_rises >= 3) && b < 60) begin step(); b++; end
    check("rst_mid_sclk_high", bus.sclk, 1'b1);
    we0   = we_seen;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs_n", bus.cs_n, 1'b1);
    check("rst_mid_sclk", bus.sclk, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    step();
    step();
    rst_n     = 1'b1;
    r0        = cyc;
    busy_seen = 1'b0;
    repeat (PER - 2) begin
      step();
      if (busy) busy_seen = 1'b1;
    end
    check("post_rst_busy_low", busy_seen, 1'b0);
    check("post_rst_no_we", we_seen, we0);
    check("post_rst_data", bus.data_out, 16'h0);
    do_conv(16'h3C96, 1'b0, r0 + PER, 1'b1, 16'h3C96, 16'h0, "post_rst");

    check("we_never_double", we_double, 0);
    check("sclk_idle_with_cs_high", sclk_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
